// File: rtl/aq_lsu_spsram_ctrl_64x58_pkg.sv
// -----------------------------------------------------------------------------
// aq_lsu_spsram_ctrl_64x58_pkg
//
// Shared LSU SRAM front-end constants: geometry of the 64x58 single-port macro
// and the controller state encoding. Imported by the controller top and its
// response skid buffer.
// -----------------------------------------------------------------------------
package aq_lsu_spsram_ctrl_64x58_pkg;

    // Macro geometry. DEPTH must always equal 2**ADDR_WIDTH so the init
    // counter covers every entry exactly once before wrapping.
    localparam int LSU_SRAM_ADDR_WIDTH = 6;
    localparam int LSU_SRAM_DATA_WIDTH = 58;
    localparam int LSU_SRAM_DEPTH      = 64;

    // Controller states.
    //   ST_INIT  : zero-fill sweep over all entries, one write per cycle
    //   ST_RUN   : normal request service
    //   ST_DRAIN : invalidate seen with a read response still outstanding;
    //              wait for the consumer before starting the zero-fill
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ctrl_state_e;

endpackage : aq_lsu_spsram_ctrl_64x58_pkg

// File: rtl/aq_lsu_spsram_rsp_buf.sv
// -----------------------------------------------------------------------------
// aq_lsu_spsram_rsp_buf
//
// One-entry skid buffer for SRAM read responses. The macro presents Q the
// cycle after a read strobe (r_rd_pend). If the consumer is not ready in that
// cycle, Q is captured into r_hold_data and replayed until it is taken.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_b      synchronous active-low reset; also masks o_rsp_vld while low
//   i_rd_acc     a read request was accepted this cycle
//   i_sram_q     macro Q output
//   i_rsp_rdy    consumer ready
//   o_rsp_vld    read data valid
//   o_rsp_rdata  read data (live Q or held copy)
//   o_rd_pend    macro Q carries a response this cycle
//   o_hold_vld   skid buffer holds an untaken response
// -----------------------------------------------------------------------------
module aq_lsu_spsram_rsp_buf
    import aq_lsu_spsram_ctrl_64x58_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_SRAM_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_b,
    input  logic                  i_rd_acc,
    input  logic [DATA_WIDTH-1:0] i_sram_q,
    input  logic                  i_rsp_rdy,
    output logic                  o_rsp_vld,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rd_pend,
    output logic                  o_hold_vld
);

    logic                  r_rd_pend;
    logic                  r_hold_vld;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  w_capture;

    // Response is live on Q but nobody takes it: park it in the buffer.
    // The request side refuses new reads in exactly this situation, so a
    // capture never coincides with a new read landing on Q, and r_rd_pend
    // and r_hold_vld are never set together.
    assign w_capture = r_rd_pend & ~i_rsp_rdy;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours regardless of block order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_b) begin
            r_rd_pend  <= 1'b0;
            r_hold_vld <= 1'b0;
        end else begin
            r_rd_pend <= i_rd_acc;
            if (w_capture) begin
                r_hold_vld <= 1'b1;
            end else if (r_hold_vld && i_rsp_rdy) begin
                r_hold_vld <= 1'b0;
            end
        end
    end

    // NOTE: the data register carries no reset; it is only observed while
    // r_hold_vld is set, and leaving it out of reset keeps the wide datapath
    // free of reset fan-out.
    always_ff @(posedge i_clk) begin
        if (w_capture) begin
            r_hold_data <= i_sram_q;
        end
    end

    // Reset masks the valid immediately, before the synchronous clear lands,
    // so an outstanding response is dropped rather than presented.
    assign o_rsp_vld   = i_rst_b & (r_rd_pend | r_hold_vld);
    assign o_rsp_rdata = r_hold_vld ? r_hold_data : i_sram_q;
    assign o_rd_pend   = r_rd_pend;
    assign o_hold_vld  = r_hold_vld;

endmodule : aq_lsu_spsram_rsp_buf

// File: rtl/aq_lsu_spsram_ctrl_64x58.sv
// -----------------------------------------------------------------------------
// aq_lsu_spsram_ctrl_64x58
//
// Front-end controller for the LSU 64x58 single-port SRAM macro. Accepts
// valid/ready read and write requests, drives the macro's active-low strobes,
// returns read data through a one-entry skid buffer, and zero-fills all
// entries after reset and whenever inv_req is raised in RUN.
//
// The macro itself sits in the parent; this block only produces its pins.
// DEPTH must equal 2**ADDR_WIDTH.
//
// Ports:
//   forever_cpuclk  clock, rising edge
//   cpurst_b        synchronous active-low reset
//   req_vld/req_rdy request handshake
//   req_wr          1 = write, 0 = read
//   req_addr        entry index
//   req_wdata       write data
//   req_wmask       per-bit write enable, active-high
//   rsp_vld/rsp_rdy read response handshake
//   rsp_rdata       read data
//   inv_req         level request to re-initialise all entries
//   init_done       high when not initialising
//   sram_a          macro address
//   sram_cen        macro chip enable, active-low
//   sram_gwen       macro global write enable, active-low
//   sram_wen        macro per-bit write enable, active-low
//   sram_d          macro write data
//   sram_q          macro read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module aq_lsu_spsram_ctrl_64x58
    import aq_lsu_spsram_ctrl_64x58_pkg::*;
#(
    parameter int ADDR_WIDTH = LSU_SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = LSU_SRAM_DATA_WIDTH,
    parameter int DEPTH      = LSU_SRAM_DEPTH
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,

    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,

    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,

    input  logic                  inv_req,
    output logic                  init_done,

    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    ctrl_state_e           r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;

    logic w_in_init;
    logic w_in_run;
    logic w_rd_pend;
    logic w_hold_vld;
    logic w_rsp_busy;
    logic w_acc;
    logic w_rd_acc;

    // ------------------------------------------------------------------
    // State decodes. Every externally visible decode is qualified with
    // cpurst_b so the pins take their quiet values during the reset cycle
    // itself, not one cycle later when the synchronous clear lands.
    // ------------------------------------------------------------------
    assign w_in_init  = cpurst_b & (r_state == ST_INIT);
    assign w_in_run   = cpurst_b & (r_state == ST_RUN);
    assign w_rsp_busy = w_rd_pend | w_hold_vld;

    // A new read may only be accepted if its response has somewhere to go
    // next cycle: the buffer is empty, or the live response is being taken
    // right now. inv_req blocks acceptance so the drain decision is final.
    assign req_rdy   = w_in_run & ~inv_req & ~w_hold_vld & ~(w_rd_pend & ~rsp_rdy);
    assign w_acc     = req_vld & req_rdy;
    assign w_rd_acc  = w_acc & ~req_wr;
    assign init_done = cpurst_b & (r_state != ST_INIT);

    // ------------------------------------------------------------------
    // Control FSM and init address counter.
    // ------------------------------------------------------------------
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_INIT: begin
                    // inv_req is deliberately ignored here: a sweep already
                    // in progress satisfies any invalidate.
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + ADDR_ONE;
                    end
                end
                ST_RUN: begin
                    if (inv_req) begin
                        r_state <= w_rsp_busy ? ST_DRAIN : ST_INIT;
                        r_cnt   <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (!w_rsp_busy) begin
                        r_state <= ST_INIT;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Macro pin decode.
    // ------------------------------------------------------------------
    // NOTE: every output gets a default at the top of the block so no path
    // through the if-chain leaves a signal unassigned and infers a latch.
    always_comb begin
        sram_a    = req_addr;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_d    = req_wdata;

        if (w_in_init) begin
            // Full-width zero write to the sweep address.
            sram_a    = r_cnt;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_d    = '0;
        end else if (w_acc) begin
            sram_cen = 1'b0;
            if (req_wr) begin
                // An all-zero mask still strobes the macro; it simply
                // changes no bits.
                sram_gwen = 1'b0;
                sram_wen  = ~req_wmask;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read response skid buffer.
    // ------------------------------------------------------------------
    aq_lsu_spsram_rsp_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_buf (
        .i_clk       (forever_cpuclk),
        .i_rst_b     (cpurst_b),
        .i_rd_acc    (w_rd_acc),
        .i_sram_q    (sram_q),
        .i_rsp_rdy   (rsp_rdy),
        .o_rsp_vld   (rsp_vld),
        .o_rsp_rdata (rsp_rdata),
        .o_rd_pend   (w_rd_pend),
        .o_hold_vld  (w_hold_vld)
    );

endmodule : aq_lsu_spsram_ctrl_64x58

// File: tb/tb_aq_lsu_spsram_ctrl_64x58.sv
// -----------------------------------------------------------------------------
// tb_aq_lsu_spsram_ctrl_64x58
//
// Self-checking bench for the LSU SRAM front-end controller. A behavioural
// model of the 64x58 macro sits on the sram_* pins; its Q output carries
// random junk on every cycle without a read strobe. Expected read data comes
// from a separate reference array updated by the bench from the masked-write
// rule, and an in-order queue of expected responses.
// -----------------------------------------------------------------------------
module tb_aq_lsu_spsram_ctrl_64x58;

    localparam int AW    = 6;
    localparam int DW    = 58;
    localparam int DEPTH = 64;

    logic          clk       = 1'b0;
    logic          rst_b     = 1'b0;
    logic          req_vld   = 1'b0;
    logic          req_rdy;
    logic          req_wr    = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [DW-1:0] req_wmask = '0;
    logic          rsp_vld;
    logic          rsp_rdy   = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          inv_req   = 1'b0;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    aq_lsu_spsram_ctrl_64x58 #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_b),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .rsp_vld        (rsp_vld),
        .rsp_rdy        (rsp_rdy),
        .rsp_rdata      (rsp_rdata),
        .inv_req        (inv_req),
        .init_done      (init_done),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    function automatic logic [DW-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // Macro model: bit-masked write where WEN is low, Q updated on reads,
    // junk on Q otherwise so a stale Q can never masquerade as held data.
    logic [DW-1:0] sram_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = rand_word();
        sram_q = rand_word();
    end
    always @(posedge clk) begin
        if (!sram_cen && !sram_gwen) begin
            sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            sram_q           <= rand_word();
        end else if (!sram_cen) begin
            sram_q <= sram_mem[sram_a];
        end else begin
            sram_q <= rand_word();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_q.delete();
    endtask

    // Issue one request, waiting (bounded) for req_rdy. Checks the macro
    // strobes in the accept cycle and updates the reference memory. Returns
    // one cycle after acceptance with req_vld dropped.
    task automatic issue(input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [DW-1:0] mask);
        int waited;
        logic [AW+DW+1:0] exp_s;
        waited    = 0;
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        req_wmask = mask;
        @(negedge clk);
        while (req_rdy !== 1'b1 && waited < 16) begin
            tick();
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (req_rdy !== 1'b1) $display("FAIL issue_rdy: req_rdy=%b after %0d cycles, want 1", req_rdy, waited);
        else n_pass++;
        exp_s = {1'b0, ~wr, addr, (wr ? ~mask : {DW{1'b1}})};
        n_checks++;
        if ({sram_cen, sram_gwen, sram_a, sram_wen} !== exp_s)
            $display("FAIL issue_strobe: cen/gwen/a/wen=%h, want %h", {sram_cen, sram_gwen, sram_a, sram_wen}, exp_s);
        else n_pass++;
        if (wr) begin
            n_checks++;
            if (sram_d !== data) $display("FAIL issue_wdata: sram_d=%h, want %h", sram_d, data);
            else n_pass++;
            ref_mem[addr] = (ref_mem[addr] & ~mask) | (data & mask);
        end
        tick();
        req_vld = 1'b0;
    endtask

    // Read one entry with rsp_rdy=1 and check the response next cycle.
    task automatic read_expect(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
        rsp_rdy = 1'b1;
        issue(1'b0, addr, '0, '0);
        @(negedge clk);
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== exp)
            $display("FAIL %s: addr %0d rsp_vld=%b rdata=%h, want 1 / %h", name, addr, rsp_vld, rsp_rdata, exp);
        else n_pass++;
        tick();
    endtask

    // Called at the start of INIT cycle 0. Random requests and inv_req are
    // applied throughout; all must be ignored. Expects 64 zero writes to
    // 0..63, then init_done/req_rdy high in cycle 64.
    task automatic check_init_seq(input string name);
        int good;
        good = 0;
        for (int c = 0; c < DEPTH; c++) begin
            req_vld  = 1'($urandom_range(0, 1));
            req_wr   = 1'($urandom_range(0, 1));
            req_addr = AW'($urandom_range(0, DEPTH - 1));
            inv_req  = 1'($urandom_range(0, 1));
            rsp_rdy  = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (sram_cen === 1'b0 && sram_gwen === 1'b0 && sram_wen === '0 && sram_d === '0 &&
                sram_a === AW'(c) && init_done === 1'b0 && req_rdy === 1'b0 && rsp_vld === 1'b0)
                good++;
            tick();
        end
        req_vld = 1'b0;
        inv_req = 1'b0;
        rsp_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (good !== DEPTH) $display("FAIL %s_strobes: %0d correct init cycles, want %0d", name, good, DEPTH);
        else n_pass++;
        n_checks++;
        if ({init_done, req_rdy, sram_cen, rsp_vld} !== 4'b1110)
            $display("FAIL %s_done: init_done/req_rdy/cen/rsp_vld=%b at cycle 64, want 1110", name,
                     {init_done, req_rdy, sram_cen, rsp_vld});
        else n_pass++;
        tick();
        clear_model();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            req_vld  = 1'($urandom_range(0, 1));
            req_wr   = 1'($urandom_range(0, 1));
            inv_req  = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++;
            if ({sram_cen, sram_gwen, sram_wen, req_rdy, rsp_vld, init_done} !== {2'b11, {DW{1'b1}}, 3'b000})
                $display("FAIL reset_outputs: cen=%b gwen=%b wen=%h rdy=%b vld=%b done=%b", sram_cen, sram_gwen,
                         sram_wen, req_rdy, rsp_vld, init_done);
            else n_pass++;
            tick();
        end
        rst_b = 1'b1;
        check_init_seq("reset_init");
        for (int a = 0; a < DEPTH; a++) read_expect(AW'(a), '0, "init_zero");
    endtask

    task automatic test_masked_write();
        logic [DW-1:0] junk;
        issue(1'b1, 6'd5, 58'h3FF_FFFF_FFFF_FFFF, {DW{1'b1}});
        issue(1'b1, 6'd5, '0, 58'hF);
        read_expect(6'd5, 58'h3FF_FFFF_FFFF_FFF0, "masked_write");
        junk = rand_word();
        issue(1'b1, 6'd5, junk, '0);
        read_expect(6'd5, 58'h3FF_FFFF_FFFF_FFF0, "zero_mask_write");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d1, d2, d3;
        d1 = rand_word();
        d2 = rand_word();
        d3 = rand_word();
        issue(1'b1, 6'd1, d1, {DW{1'b1}});
        issue(1'b1, 6'd2, d2, {DW{1'b1}});
        rsp_rdy = 1'b1;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 6'd1;
        @(negedge clk);
        n_checks++;
        if ({req_rdy, sram_cen, sram_a} !== {2'b10, 6'd1}) $display("FAIL b2b_rd1: rdy/cen/a=%h", {req_rdy, sram_cen, sram_a});
        else n_pass++;
        tick();
        req_addr = 6'd2;
        @(negedge clk);
        n_checks++;
        if ({req_rdy, sram_cen, sram_a} !== {2'b10, 6'd2}) $display("FAIL b2b_rd2: rdy/cen/a=%h", {req_rdy, sram_cen, sram_a});
        else n_pass++;
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== d1) $display("FAIL b2b_rsp1: vld=%b rdata=%h, want 1 / %h", rsp_vld, rsp_rdata, d1);
        else n_pass++;
        tick();
        req_wr = 1'b1; req_addr = 6'd9; req_wdata = d3; req_wmask = {DW{1'b1}};
        @(negedge clk);
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== d2) $display("FAIL b2b_rsp2: vld=%b rdata=%h, want 1 / %h", rsp_vld, rsp_rdata, d2);
        else n_pass++;
        n_checks++;
        if (req_rdy !== 1'b1) $display("FAIL b2b_wr_rdy: req_rdy=%b, want 1", req_rdy);
        else n_pass++;
        ref_mem[9] = d3;
        tick();
        req_wr = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rsp_vld, req_rdy} !== 2'b01) $display("FAIL wr_no_rsp: rsp_vld/req_rdy=%b, want 01", {rsp_vld, req_rdy});
        else n_pass++;
        tick();
        req_vld = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== d3) $display("FAIL wr_then_rd: vld=%b rdata=%h, want 1 / %h", rsp_vld, rsp_rdata, d3);
        else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        issue(1'b1, 6'd7, 58'h123, {DW{1'b1}});
        rsp_rdy = 1'b0;
        issue(1'b0, 6'd7, '0, '0);
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 6'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({rsp_vld, req_rdy, sram_cen} !== 3'b101 || rsp_rdata !== 58'h123)
                $display("FAIL bp_hold%0d: vld/rdy/cen=%b rdata=%h, want 101 / 123", i, {rsp_vld, req_rdy, sram_cen}, rsp_rdata);
            else n_pass++;
            tick();
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rsp_vld, req_rdy} !== 2'b10 || rsp_rdata !== 58'h123)
            $display("FAIL bp_take: vld/rdy=%b rdata=%h, want 10 / 123", {rsp_vld, req_rdy}, rsp_rdata);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if ({rsp_vld, req_rdy, sram_cen} !== 3'b010) $display("FAIL bp_release: vld/rdy/cen=%b, want 010", {rsp_vld, req_rdy, sram_cen});
        else n_pass++;
        tick();
        req_vld = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== ref_mem[0]) $display("FAIL bp_next_rd: vld=%b rdata=%h, want 1 / %h", rsp_vld, rsp_rdata, ref_mem[0]);
        else n_pass++;
        tick();
    endtask

    // Random traffic against the scoreboard. The response path is a single
    // slot: a response that is not taken in its first visible cycle becomes
    // parked, and a parked response blocks new requests until taken.
    task automatic test_random();
        bit exp_rdy, acc, parked;
        logic [DW-1:0] mask;
        logic [AW+DW+1:0] exp_s;
        parked = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit idle;
            idle      = (cyc >= 397);
            req_vld   = idle ? 1'b0 : 1'($urandom_range(0, 1));
            req_wr    = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, DEPTH - 1));
            req_wdata = rand_word();
            case ($urandom_range(0, 3))
                0:       mask = {DW{1'b1}};
                1:       mask = '0;
                default: mask = rand_word();
            endcase
            req_wmask = mask;
            rsp_rdy   = idle ? 1'b1 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && rsp_rdy && !parked);
            acc     = req_vld && exp_rdy;
            n_checks++;
            if (req_rdy !== exp_rdy) $display("FAIL rnd_rdy: cycle %0d req_rdy=%b, want %b", cyc, req_rdy, exp_rdy);
            else n_pass++;
            n_checks++;
            if (rsp_vld !== (exp_q.size() != 0)) $display("FAIL rnd_vld: cycle %0d rsp_vld=%b, want %b", cyc, rsp_vld, exp_q.size() != 0);
            else n_pass++;
            if (exp_q.size() != 0) begin
                n_checks++;
                if (rsp_rdata !== exp_q[0]) $display("FAIL rnd_data: cycle %0d rdata=%h, want %h", cyc, rsp_rdata, exp_q[0]);
                else n_pass++;
            end
            exp_s = acc ? {1'b0, ~req_wr, req_addr, (req_wr ? ~mask : {DW{1'b1}})} : {2'b11, sram_a, {DW{1'b1}}};
            n_checks++;
            if ({sram_cen, sram_gwen, sram_a, sram_wen} !== exp_s)
                $display("FAIL rnd_strobe: cycle %0d cen/gwen/a/wen=%h, want %h", cyc, {sram_cen, sram_gwen, sram_a, sram_wen}, exp_s);
            else n_pass++;
            if (acc && req_wr) begin
                n_checks++;
                if (sram_d !== req_wdata) $display("FAIL rnd_wdata: cycle %0d sram_d=%h, want %h", cyc, sram_d, req_wdata);
                else n_pass++;
            end
            if (exp_q.size() != 0) begin
                if (rsp_rdy) begin
                    void'(exp_q.pop_front());
                    parked = 1'b0;
                end else begin
                    parked = 1'b1;
                end
            end
            if (acc) begin
                if (req_wr) ref_mem[req_addr] = (ref_mem[req_addr] & ~mask) | (req_wdata & mask);
                else        exp_q.push_back(ref_mem[req_addr]);
            end
            tick();
        end
        req_vld = 1'b0;
    endtask

    task automatic test_invalidate();
        logic [DW-1:0] d;
        d = rand_word() | 58'h1;
        issue(1'b1, 6'd11, d, {DW{1'b1}});
        rsp_rdy = 1'b0;
        issue(1'b0, 6'd11, '0, '0);
        // Response live on Q; raise invalidate together with a new request.
        inv_req = 1'b1; req_vld = 1'b1; req_wr = 1'b0; req_addr = 6'd3;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rsp_rdy = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({rsp_vld, req_rdy, sram_cen, init_done} !== 4'b1011 || rsp_rdata !== d)
                $display("FAIL inv_drain%0d: vld/rdy/cen/done=%b rdata=%h, want 1011 / %h", i,
                         {rsp_vld, req_rdy, sram_cen, init_done}, rsp_rdata, d);
            else n_pass++;
            tick();
        end
        // Response taken; one more DRAIN cycle with nothing outstanding.
        @(negedge clk);
        n_checks++;
        if ({rsp_vld, req_rdy, sram_cen, init_done} !== 4'b0011)
            $display("FAIL inv_drained: vld/rdy/cen/done=%b, want 0011", {rsp_vld, req_rdy, sram_cen, init_done});
        else n_pass++;
        tick();
        check_init_seq("inv_init");
        for (int a = 0; a < DEPTH; a++) read_expect(AW'(a), '0, "inv_zero");
    endtask

    task automatic test_inv_idle();
        issue(1'b1, 6'd33, rand_word() | 58'h1, {DW{1'b1}});
        inv_req = 1'b1; req_vld = 1'b1; req_wr = 1'b1; req_addr = 6'd34; req_wdata = rand_word();
        @(negedge clk);
        n_checks++;
        if ({req_rdy, sram_cen, init_done} !== 3'b011) $display("FAIL inv_idle_cycle: rdy/cen/done=%b, want 011", {req_rdy, sram_cen, init_done});
        else n_pass++;
        tick();
        check_init_seq("inv_idle_init");
        read_expect(6'd33, '0, "inv_idle_zero33");
        read_expect(6'd34, '0, "inv_idle_zero34");
    endtask

    task automatic test_reset_mid_init();
        int good;
        issue(1'b1, 6'd20, rand_word() | 58'h1, {DW{1'b1}});
        rsp_rdy = 1'b0;
        issue(1'b0, 6'd20, '0, '0);
        tick();
        // A parked response is outstanding; reset must discard it.
        rst_b = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rsp_vld, req_rdy, sram_cen, init_done} !== 4'b0010)
            $display("FAIL rst_discard: vld/rdy/cen/done=%b, want 0010", {rsp_vld, req_rdy, sram_cen, init_done});
        else n_pass++;
        tick();
        rst_b = 1'b1;
        good  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sram_cen === 1'b0 && sram_gwen === 1'b0 && sram_a === AW'(c) && rsp_vld === 1'b0 && init_done === 1'b0)
                good++;
            tick();
        end
        n_checks++;
        if (good !== 20) $display("FAIL mid_init_partial: %0d correct init cycles, want 20", good);
        else n_pass++;
        rst_b = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({sram_cen, sram_gwen, rsp_vld, init_done} !== 4'b1100)
            $display("FAIL mid_init_reset: cen/gwen/vld/done=%b, want 1100", {sram_cen, sram_gwen, rsp_vld, init_done});
        else n_pass++;
        tick();
        rst_b = 1'b1;
        check_init_seq("mid_init_restart");
        read_expect(6'd20, '0, "mid_init_zero");
    endtask

    initial begin
        clear_model();
        test_reset();
        test_masked_write();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_invalidate();
        test_inv_idle();
        test_reset_mid_init();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_aq_lsu_spsram_ctrl_64x58

// File: doc/aq_lsu_spsram_ctrl_64x58.md
# aq_lsu_spsram_ctrl_64x58

Front-end controller for the LSU 64-entry × 58-bit single-port SRAM (`aq_spsram_64x58`). It takes valid/ready read and write requests from LSU logic and drives the macro's active-low strobes. It returns read data through a one-entry skid buffer. After reset, and on request, it zero-initialises all 64 entries.

## Interface
Parameters:
- ADDR_WIDTH, 6, SRAM address width.
- DATA_WIDTH, 58, SRAM data width.
- DEPTH, 64, entry count; must equal 2^ADDR_WIDTH.

Ports:
- forever_cpuclk  in  1  single clock; all state updates on its rising edge.
- cpurst_b  in  1  reset; synchronous, active-low.
- req_vld  in  1  request valid.
- req_rdy  out  1  request accepted when req_vld & req_rdy.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  entry index.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  DATA_WIDTH  per-bit write enable, active-high.
- rsp_vld  out  1  read data valid.
- rsp_rdy  in  1  consumer ready.
- rsp_rdata  out  DATA_WIDTH  read data.
- inv_req  in  1  level request to re-initialise all entries.
- init_done  out  1  high when not initialising.
- sram_a  out  ADDR_WIDTH  to macro A.
- sram_cen  out  1  to macro CEN, active-low.
- sram_gwen  out  1  to macro GWEN, active-low global write.
- sram_wen  out  DATA_WIDTH  to macro WEN, active-low per bit.
- sram_d  out  DATA_WIDTH  to macro D.
- sram_q  in  DATA_WIDTH  from macro Q; valid the cycle after a read strobe.

## Operation
- **State machine.** States are INIT, RUN and DRAIN.
  - Reset state is INIT.
  - INIT → RUN after the write to entry DEPTH-1.
  - RUN → DRAIN when inv_req=1 and a response is outstanding (rd_pend or hold_vld).
  - RUN → INIT when inv_req=1 and no response is outstanding.
  - DRAIN → INIT once rd_pend=0 and hold_vld=0.
  - inv_req is ignored in INIT.
- **INIT.**
  - One write per cycle, address counter cnt running 0..DEPTH-1.
  - Drives sram_cen=0, sram_gwen=0, sram_wen=0, sram_d=0.
  - cnt clears on entry to INIT.
  - Holds req_rdy=0 and init_done=0.
- **RUN, request side.**
  - req_rdy = ~inv_req & ~hold_vld & ~(rd_pend & ~rsp_rdy).
  - On an accepted request: sram_cen=0, sram_a=req_addr.
  - Write: sram_gwen=0, sram_wen=~req_wmask, sram_d=req_wdata. A write with an all-zero mask is still issued.
  - Read: sram_gwen=1, sram_wen all 1.
  - No accepted request: sram_cen=1, sram_gwen=1, sram_wen all 1.
- **DRAIN.** req_rdy=0 and sram_cen=1.
- **Read response.**
  - rd_pend is set in the cycle after a read is accepted.
  - In that cycle, rsp_vld=1 and rsp_rdata=sram_q.
  - If rsp_rdy=0 in that cycle, sram_q is captured into hold_data and hold_vld is set.
  - While hold_vld=1: rsp_vld=1 and rsp_rdata=hold_data; hold_vld clears on rsp_rdy=1.
  - hold_vld and rd_pend are never both 1.
- **Writes** produce no response.
- **Reset while cpurst_b=0:**
  - State → INIT, cnt=0, rd_pend=0, hold_vld=0.
  - Outputs forced to sram_cen=1, sram_gwen=1, sram_wen all 1, req_rdy=0, rsp_vld=0, init_done=0.
  - Outstanding responses are discarded.
- **Simultaneous events.**
  - If inv_req and req_vld are both high in RUN, the request is not accepted.
  - If reset coincides with any event, reset wins.

## Timing
- Cycle 0 is the first cycle with cpurst_b=1.
- Cycles 0..63: INIT writes entries 0..63.
- Cycle 64: state is RUN, init_done=1, req_rdy may be 1. Total initialisation is 64 cycles.
- Read accepted in cycle N gives rsp_vld=1 in cycle N+1, with no bubble when rsp_rdy=1. Back-to-back reads sustain one per cycle.
- A write in cycle N followed by a read of the same address in cycle N+1 returns the written data.
- inv_req sampled in RUN with nothing outstanding at cycle N:
  - INIT is entered at N+1 and init_done=0 at N+1.
  - init_done returns to 1 at N+65.
- init_done, req_rdy and the sram_* outputs are combinational decodes of registered state plus inputs; no input-to-input combinational loops.

## Structure
- Constants go in the shared LSU header: state encodings (INIT, RUN, DRAIN), ADDR_WIDTH, DATA_WIDTH, DEPTH.
- One sub-module: `aq_lsu_spsram_rsp_buf`. It holds the one-entry skid buffer (rd_pend, hold_vld, hold_data) and the rsp_* outputs.
- The macro `aq_spsram_64x58` is instantiated by the parent, not inside this block.

## Test plan
- **Reset and init.** Release reset, then read all 64 entries → each returns 0x0. Check exactly 64 INIT write strobes at addresses 0..63 and init_done rising at cycle 64.
- **Masked write.**
  - Write addr 5, data 0x3FF_FFFF_FFFF_FFFF, full mask.
  - Then write addr 5, data 0, mask 0x00F.
  - Read addr 5 → 0x3FF_FFFF_FFFF_FFF0.
- **Back-to-back reads with rsp_rdy=1.** Read addr 1 and addr 2 in consecutive cycles → rsp_vld high for two consecutive cycles with correct data.
- **Backpressure.**
  - Read addr 7 (pre-written 0x123), rsp_rdy=0 for 3 cycles.
  - Required: rsp_vld held, rsp_rdata=0x123 stable, req_rdy=0 until the response is taken.
- **Invalidate.**
  - Assert inv_req with one read outstanding and rsp_rdy=0 → DRAIN; the response is delivered once rsp_rdy=1.
  - Then INIT runs 64 cycles; all entries subsequently read 0.
- **Reset mid-INIT.** Assert cpurst_b=0 at cycle 20 of INIT for one cycle → cnt restarts at 0, init_done rises 64 cycles after release, with no response emitted.
